layer_code: RTL and testbench

LAYER_CODE -- requirements
Module: layer_code

---
 rtl/layer_code.sv | 147 ++++++++++++++
 tb/tb_layer_code.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_code.sv
// Serial LED encoder: shifts 24-bit GRB pixels out MSB first as pulse-width
// coded bits, with an optional latch (reset-code) low period after a pixel.
module layer_code #(
  parameter logic [15:0] RST_CYCLES = 16'd20000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  t0h_cnt_in,
  input  logic [7:0]  t0l_cnt_in,
  input  logic [7:0]  t1h_cnt_in,
  input  logic [7:0]  t1l_cnt_in,
  input  logic [23:0] pix_data_in,
  input  logic        pix_valid_in,
  output logic        pix_ready_out,
  input  logic        frame_end_in,
  output logic        bit_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t             state, state_nxt;
  logic [PIX_W-1:0]   shreg, shreg_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [7:0]         t0h_q, t0l_q, t1h_q, t1l_q;
  logic [7:0]         t0h_nxt, t0l_nxt, t1h_nxt, t1l_nxt;
  logic               pending, pending_nxt;
  logic               done_nxt;
  logic [7:0]         high_len, low_len;
  logic               phase_last, latch_last, transfer;

  // Phase lengths come from the timing counts captured with the pixel.
  assign high_len   = shreg[PIX_W-1] ? t1h_q : t0h_q;
  assign low_len    = shreg[PIX_W-1] ? t1l_q : t0l_q;
  assign phase_last = ((state == HIGH) && (cnt == CNT_W'(high_len))) ||
                      ((state == LOW)  && (cnt == CNT_W'(low_len)));
  assign latch_last = (cnt == RST_CYCLES - CNT_W'(1));

  // Ready while idle or on the last low cycle of bit 0, unless a latch is owed.
  assign pix_ready_out = !rst_in && !pending &&
                         ((state == IDLE) ||
                          ((state == LOW) && phase_last && (bit_idx == IDX_W'(0))));
  assign transfer = pix_valid_in && pix_ready_out;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    cnt_nxt     = cnt + CNT_W'(1);
    t0h_nxt     = t0h_q;
    t0l_nxt     = t0l_q;
    t1h_nxt     = t1h_q;
    t1l_nxt     = t1l_q;
    pending_nxt = pending | frame_end_in;
    done_nxt    = 1'b0;

    if (transfer) begin
      shreg_nxt   = pix_data_in;
      bit_idx_nxt = IDX_W'(23);
      t0h_nxt     = t0h_cnt_in;
      t0l_nxt     = t0l_cnt_in;
      t1h_nxt     = t1h_cnt_in;
      t1l_nxt     = t1l_cnt_in;
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (transfer) begin
          state_nxt = HIGH;
        end else if (pending_nxt) begin
          state_nxt   = LATCH;
          pending_nxt = 1'b0;
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        if (phase_last) begin
          cnt_nxt = '0;
          if (bit_idx != IDX_W'(0)) begin
            state_nxt   = HIGH;
            shreg_nxt   = {shreg[PIX_W-2:0], 1'b0};
            bit_idx_nxt = bit_idx - IDX_W'(1);
          end else if (pending) begin
            // A request arriving on this very cycle is a new one and stays pending.
            state_nxt   = LATCH;
            pending_nxt = frame_end_in;
          end else if (transfer) begin
            state_nxt = HIGH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      LATCH: begin
        if (latch_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      t0h_q    <= '0;
      t0l_q    <= '0;
      t1h_q    <= '0;
      t1l_q    <= '0;
      pending  <= 1'b0;
      bit_out  <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_idx  <= bit_idx_nxt;
      cnt      <= cnt_nxt;
      t0h_q    <= t0h_nxt;
      t0l_q    <= t0l_nxt;
      t1h_q    <= t1h_nxt;
      t1l_q    <= t1l_nxt;
      pending  <= pending_nxt;
      bit_out  <= (state_nxt == HIGH);
      busy_out <= (state_nxt != IDLE);
      done_out <= done_nxt;
    end
  end

endmodule

// File: tb/tb_layer_code.sv
// Bench for layer_code: a monitor decodes bit_out high/low run lengths and
// compares them against per-bit expectations queued when each pixel is accepted.
module tb_layer_code;

  localparam logic [15:0] RST = 16'd100;

  typedef struct {
    int h;
    int l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [7:0]  t0h, t0l, t1h, t1l;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready_out;
  logic        frame_end;
  logic        bit_out;
  logic        busy_out;
  logic        done_out;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  layer_code #(.RST_CYCLES(RST)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .t0h_cnt_in   (t0h),
    .t0l_cnt_in   (t0l),
    .t1h_cnt_in   (t1h),
    .t1l_cnt_in   (t1l),
    .pix_data_in  (pix_data),
    .pix_valid_in (pix_valid),
    .pix_ready_out(pix_ready_out),
    .frame_end_in (frame_end),
    .bit_out      (bit_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Queue the 24 expected (high, low) run lengths using the counts driven now.
  task automatic push_pixel(input logic [23:0] d);
    exp_t e;
    for (int i = 23; i >= 0; i--) begin
      e.h = d[i] ? int'(t1h) + 1 : int'(t0h) + 1;
      e.l = d[i] ? int'(t1l) + 1 : int'(t0l) + 1;
      q.push_back(e);
    end
  endtask

  // Output decoder; a low run ends at the next rise or when busy drops.
  int hcnt = 0;
  int lcnt = 0;
  bit in_low = 1'b0;

  task automatic end_low();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("low_len", lcnt, e.l);
    end else begin
      chk("low_without_expect", 1, 0);
    end
    in_low = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_in) begin
      hcnt   = 0;
      in_low = 1'b0;
    end else if (bit_out) begin
      if (in_low) end_low();
      hcnt++;
    end else begin
      if (hcnt > 0) begin
        if (q.size() > 0) chk("high_len", hcnt, q[0].h);
        else              chk("unexpected_bit", 1, 0);
        hcnt   = 0;
        in_low = 1'b1;
        lcnt   = 0;
      end
      if (in_low) begin
        if (busy_out) lcnt++;
        else          end_low();
      end
    end
  end

  // Hold valid until n_pix pixels are accepted; optional event at cycle evt_at
  // (1: change t1h, 2: frame_end pulse). Returns longest busy run and done count.
  task automatic stream(input logic [23:0] d0, input logic [23:0] d1, input int n_pix,
                        input int evt_at, input int evt_kind,
                        output int busy_max, output int done_n, output int exp_busy);
    int   acc     = 0;
    int   run     = 0;
    bit   started = 1'b0;
    bit   ended   = 1'b0;
    exp_t e;
    busy_max = 0;
    done_n   = 0;
    exp_busy = 0;
    pix_data  = d0;
    pix_valid = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (acc >= n_pix) pix_valid = 1'b0;
      else if (acc >= 1) pix_data = d1;
      frame_end = 1'b0;
      if (cyc == evt_at) begin
        if (evt_kind == 1) t1h = 8'h05;
        if (evt_kind == 2) begin
          frame_end = 1'b1;
          e = q.pop_back();
          e.l += int'(RST);
          q.push_back(e);
        end
      end
      if (pix_valid && pix_ready_out) begin
        push_pixel(pix_data);
        for (int i = 23; i >= 0; i--)
          exp_busy += pix_data[i] ? int'(t1h) + int'(t1l) + 2 : int'(t0h) + int'(t0l) + 2;
        acc++;
      end
      if (done_out) done_n++;
      if (busy_out) begin
        run++;
        started = 1'b1;
        if (run > busy_max) busy_max = run;
      end else begin
        run = 0;
        if (started && acc >= n_pix && !pix_valid) begin
          ended = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    frame_end = 1'b0;
    chk("stream_finished", int'(ended), 1);
    repeat (3) @(negedge clk);
  endtask

  int  bmax, dn, eb, k, k1;
  bit  ready_seen, bit_seen, done_seen;

  initial begin
    rst_in    = 1'b1;
    pix_valid = 1'b0;
    frame_end = 1'b0;
    pix_data  = '0;
    t0h = 8'h01; t0l = 8'h12; t1h = 8'h23; t1l = 8'h34;
    repeat (3) @(negedge clk);
    chk("rst_bit_out", int'(bit_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_ready", int'(pix_ready_out), 0);
    rst_in = 1'b0;
    #1;
    chk("ready_after_rst", int'(pix_ready_out), 1);
    @(negedge clk);

    // Single pixel: long bit 23, short remainder.
    stream(24'h800000, 24'h800000, 1, -1, 0, bmax, dn, eb);
    chk("busy_single", bmax, 572);
    chk("idle_bit_out", int'(bit_out), 0);

    // Back-to-back pixels must form one unbroken busy run.
    stream(24'h800000, 24'h800000, 2, -1, 0, bmax, dn, eb);
    chk("busy_b2b", bmax, 1144);

    // Timing change mid-pixel only affects the next pixel.
    stream(24'hF0F0F0, 24'h0F0F0F, 2, 100, 1, bmax, dn, eb);
    chk("busy_tchange", bmax, eb);
    t1h = 8'h23;

    // Frame end during a pixel: latch, done, then the held pixel goes out.
    stream(24'hA5A5A5, 24'h5A5A5A, 2, 200, 2, bmax, dn, eb);
    chk("done_after_latch", dn, 1);

    // Maximum counts: 256-cycle phases on the single 1 bit.
    t1h = 8'hFF; t1l = 8'hFF;
    stream(24'h000001, 24'h000001, 1, -1, 0, bmax, dn, eb);
    chk("busy_max_cnt", bmax, eb);
    t1h = 8'h23; t1l = 8'h34;

    // Frame end alone in idle, re-requested during the latch.
    frame_end  = 1'b1;
    k          = 0;
    k1         = -1;
    ready_seen = 1'b0;
    bit_seen   = 1'b0;
    while (k < 400) begin
      @(negedge clk);
      k++;
      frame_end = (k == 50);
      if (k <= 100) begin
        if (pix_ready_out) ready_seen = 1'b1;
        if (bit_out)       bit_seen   = 1'b1;
      end
      if (done_out) begin
        if (k1 < 0) k1 = k;
        else break;
      end
    end
    frame_end = 1'b0;
    chk("latch_done_delay", k1, 101);
    chk("latch_ready_low", int'(ready_seen), 0);
    chk("latch_bit_low", int'(bit_seen), 0);
    chk("second_latch_done", k, 202);
    repeat (3) @(negedge clk);

    // Reset in the middle of bit 12 aborts without a done pulse.
    pix_data  = 24'h800000;
    pix_valid = 1'b1;
    chk("ready_before_abort", int'(pix_ready_out), 1);
    if (pix_ready_out) push_pixel(pix_data);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (305) @(negedge clk);
    rst_in    = 1'b1;
    done_seen = 1'b0;
    @(negedge clk);
    chk("abort_bit_out", int'(bit_out), 0);
    chk("abort_busy", int'(busy_out), 0);
    repeat (2) begin
      @(negedge clk);
      if (done_out) done_seen = 1'b1;
    end
    q.delete();
    rst_in = 1'b0;
    #1;
    chk("ready_after_abort", int'(pix_ready_out), 1);
    @(negedge clk);
    stream(24'hC3A55A, 24'hC3A55A, 1, -1, 0, bmax, dn, eb);
    chk("fresh_busy", bmax, eb);
    chk("abort_no_done", int'(done_seen) + dn, 0);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
